// File: rtl/fir_output_stage.sv
// FIR result requantizer: decimate, round, saturate, then buffer through a small
// output FIFO with a registered head and a sticky overflow flag.
module fir_output_stage #(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 20,
  parameter int DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic [7:0]                decim,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [IN_WIDTH:0] ONE  = {{IN_WIDTH{1'b0}}, 1'b1};
  localparam logic [IN_WIDTH:0] RND  = (ONE << SHIFT) >> 1;
  localparam logic [IN_WIDTH:0] SAT  = (ONE << OUT_WIDTH) - ONE;
  localparam logic [LW-1:0]     FULL = LW'(DEPTH);

  logic [7:0]           phase_q, phase_d;
  logic                 stg_valid_q, stg_valid_d;
  logic [OUT_WIDTH-1:0] stg_data_q, stg_data_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        count_q, count_d;
  logic [OUT_WIDTH-1:0] head_q, head_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] mem_q [DEPTH];

  logic [7:0]           dec_m;
  logic [IN_WIDTH:0]    rnd_sum, rnd_shr;
  logic [OUT_WIDTH-1:0] sat_val;
  logic                 pop, wr_ok, mem_we;

  // Extra top bit keeps the rounding carry of an all-ones input.
  assign dec_m   = (decim == 8'd0) ? 8'd1 : decim;
  assign rnd_sum = {1'b0, in_data} + RND;
  assign rnd_shr = rnd_sum >> SHIFT;
  assign sat_val = (rnd_shr > SAT) ? SAT[OUT_WIDTH-1:0] : rnd_shr[OUT_WIDTH-1:0];

  assign pop   = (count_q != '0) && out_ready;
  assign wr_ok = stg_valid_q && ((count_q != FULL) || pop);

  always_comb begin
    phase_d     = phase_q;
    stg_valid_d = 1'b0;
    stg_data_d  = stg_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    ovf_d       = ovf_q;
    mem_we      = 1'b0;
    if (clear) begin
      phase_d  = 8'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (in_valid) begin
        if (phase_q == 8'd0) begin
          stg_valid_d = 1'b1;
          stg_data_d  = sat_val;
        end
        // >= lets a shrunken ratio wrap on the very next sample.
        phase_d = (phase_q >= dec_m - 8'd1) ? 8'd0 : phase_q + 8'd1;
      end
      if (stg_valid_q && !wr_ok) ovf_d = 1'b1;
      if (wr_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !pop)      count_d = count_q + 1'b1;
      else if (!wr_ok && pop) count_d = count_q - 1'b1;
      // Head register tracks the oldest entry; holds its value once empty.
      if (pop && (count_q > LW'(1)))
        head_d = mem_q[rd_ptr_q + 1'b1];
      else if (wr_ok && ((count_q == '0) || pop))
        head_d = stg_data_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q     <= 8'd0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= stg_data_q;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign overflow  = ovf_q;
  assign level     = count_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based behavioural model.
module tb_fir_output_stage;

  localparam int IW = 36;
  localparam int OW = 16;
  localparam int SH = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic [7:0]    decim;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          overflow;
  logic [$clog2(DP):0] level;

  fir_output_stage #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DEPTH(DP)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .decim(decim), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  int     m_phase;
  bit     m_st_v;
  longint m_st_d;
  longint m_q[$];
  bit     m_ovf;
  longint m_head;
  longint popped[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint requant(input longint x);
    longint r;
    r = (x + (64'd1 << (SH - 1))) / (64'd1 << SH);
    if (r > 65535) r = 65535;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_st_v = 0; m_st_d = 0; m_q.delete(); m_ovf = 0; m_head = 0;
  endtask

  task automatic model_edge();
    bit pop;
    int m;
    if (clear) begin
      m_phase = 0; m_q.delete(); m_st_v = 0; m_ovf = 0;
    end else begin
      pop = (m_q.size() > 0) && out_ready;
      m = (decim == 0) ? 1 : int'(decim);
      if (pop) void'(m_q.pop_front());
      if (m_st_v) begin
        if (m_q.size() == DP) m_ovf = 1;
        else m_q.push_back(m_st_d);
      end
      if (in_valid && m_phase == 0) begin
        m_st_v = 1; m_st_d = requant(longint'(in_data));
      end else m_st_v = 0;
      if (in_valid) m_phase = (m_phase >= m - 1) ? 0 : m_phase + 1;
    end
    if (m_q.size() > 0) m_head = m_q[0];
  endtask

  task automatic compare_all();
    chk("out_valid", longint'(out_valid), longint'(m_q.size() > 0));
    chk("level", longint'(level), longint'(m_q.size()));
    chk("overflow", longint'(overflow), longint'(m_ovf));
    chk("out_data", longint'(out_data), m_head);
  endtask

  task automatic step(input bit v, input longint d, input bit rdy, input bit clr);
    in_valid = v; in_data = d[IW-1:0]; out_ready = rdy; clear = clr;
    if (out_valid && rdy && !clr) popped.push_back(longint'(out_data));
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called just after a sampling point; reset is asserted between clock edges.
  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_level", longint'(level), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_out_data", longint'(out_data), 0);
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    #2 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b1; in_valid = 0; in_data = '0; decim = 8'd1; clear = 0; out_ready = 0;
    #2;
    apply_reset();

    // Single sample, 2-cycle latency, one-cycle visibility
    decim = 8'd1;
    step(1, 'h18, 1, 0);
    chk("lat_e1_valid", longint'(out_valid), 0);
    step(0, 0, 1, 0);
    chk("lat_e2_valid", longint'(out_valid), 1);
    chk("lat_e2_data", longint'(out_data), 'h2);
    step(0, 0, 1, 0);
    chk("lat_e3_valid", longint'(out_valid), 0);

    // Saturation and rounding boundaries
    step(1, 'h100000, 1, 0);
    step(1, 'hFFFF7, 1, 0);
    chk("sat_big", longint'(out_data), 'hFFFF);
    step(1, 'h7, 1, 0);
    chk("sat_edge", longint'(out_data), 'hFFFF);
    step(0, 0, 1, 0);
    chk("round_small", longint'(out_data), 'h0);
    step(0, 0, 1, 0);

    // Decimation by 3
    popped.delete();
    decim = 8'd3;
    for (int i = 1; i <= 9; i++) step(1, longint'(i) << 4, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("dec3_count", longint'(popped.size()), 3);
    if (popped.size() == 3) begin
      chk("dec3_v0", popped[0], 1);
      chk("dec3_v1", popped[1], 4);
      chk("dec3_v2", popped[2], 7);
    end

    // Overflow on a full FIFO, then clear
    decim = 8'd1;
    step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1, longint'(10 + i) << 4, 0, 0);
    step(0, 0, 0, 0);
    chk("ovf_level", longint'(level), 4);
    chk("ovf_flag", longint'(overflow), 1);
    chk("ovf_head", longint'(out_data), 10);
    step(0, 0, 0, 1);
    chk("clr_level", longint'(level), 0);
    chk("clr_flag", longint'(overflow), 0);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 5; i++) step(1, longint'(20 + i) << 4, 0, 0);
    popped.delete();
    for (int i = 0; i < 10; i++) step(1, longint'(25 + i) << 4, 1, 0);
    chk("full_level", longint'(level), 4);
    chk("full_ovf", longint'(overflow), 0);
    chk("full_npop", longint'(popped.size()), 10);
    for (int i = 0; i < popped.size() && i < 10; i++) chk("full_order", popped[i], 20 + i);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // Reset mid-stream with level 3
    for (int i = 0; i < 3; i++) step(1, longint'(40 + i) << 4, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_level", longint'(level), 3);
    apply_reset();
    step(1, longint'('h55) << 4, 1, 0);
    chk("post_rst_e1", longint'(out_valid), 0);
    step(0, 0, 1, 0);
    chk("post_rst_e2_valid", longint'(out_valid), 1);
    chk("post_rst_e2_data", longint'(out_data), 'h55);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      longint d;
      if ($urandom_range(0, 400) == 0) apply_reset();
      if ($urandom_range(0, 40) == 0) decim = 8'($urandom_range(0, 4));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) d = d & 64'h1FFFFF;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
           $urandom_range(0, 80) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
